trigger_tx: RTL and testbench

- Central-side transmitter for the DI2C trigger link. It is the master counterpart of the sub-system trigger receivers.
- On each accepted trigger request it sends one frame over the differential SCL/SDA transceivers: START, 8 bytes, STOP.
- Frame bytes, in order: sub_system_id, trigger_type, serial[31:24], [23:16], [15:8], [7:0], crc[15:8], crc[7:0].
- It monitors the wired busy line from the sub-systems and refuses new triggers while any sub-system is busy.

---
 rtl/trig_pkg.sv | 34 +++
 rtl/trigger_tx_if.sv | 14 +
 rtl/crc16_kermit_serial.sv | 29 ++
 rtl/trigger_tx.sv | 241 ++++++++++++++++++++++++
 tb/tb_trigger_tx.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/trig_pkg.sv
// Shared definitions for the DI2C trigger link (transmitter and receivers).
// Holds the FSM state encoding, frame geometry, CRC-16/KERMIT constants and
// the position of each field inside the 8-byte frame.
package trig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRC,
        ST_START,
        ST_BITS,
        ST_STOP,
        ST_GAP
    } state_t;

    localparam int FRAME_BYTES   = 8;
    localparam int BITS_PER_BYTE = 9;                          // 8 data + ack slot
    localparam int CELLS         = FRAME_BYTES * BITS_PER_BYTE;
    localparam int CRC_BYTES     = 6;                          // bytes covered by the CRC
    localparam int CRC_BITS      = CRC_BYTES * 8;

    localparam logic [15:0] CRC_POLY = 16'h8408;               // 0x1021 reflected
    localparam logic [15:0] CRC_INIT = 16'h0000;

    // Byte order on the wire
    localparam int BYTE_ID    = 0;
    localparam int BYTE_TYPE  = 1;
    localparam int BYTE_SER3  = 2;
    localparam int BYTE_SER2  = 3;
    localparam int BYTE_SER1  = 4;
    localparam int BYTE_SER0  = 5;
    localparam int BYTE_CRC_H = 6;
    localparam int BYTE_CRC_L = 7;

endpackage

// File: rtl/trigger_tx_if.sv
// Trigger request handshake between the trigger source and trigger_tx.
//   trig_req       source -> tx   level request
//   trig_ready     tx -> source   request accepted on this cycle if high
//   sub_system_id  source -> tx   sampled on accept
//   trigger_type   source -> tx   sampled on accept
interface trigger_tx_if;
    logic       trig_req;
    logic       trig_ready;
    logic [7:0] sub_system_id;
    logic [7:0] trigger_type;

    modport master (output trig_req, sub_system_id, trigger_type, input trig_ready);
    modport slave  (input trig_req, sub_system_id, trigger_type, output trig_ready);
endinterface

// File: rtl/crc16_kermit_serial.sv
// Bit-serial CRC-16/KERMIT, one message bit per enabled cycle. Feed each byte
// LSB first. Shared algorithm with the trigger receivers.
//   clk, reset  clock, synchronous active-high reset
//   clr         reload the init value (priority over en)
//   en          absorb bit_in this cycle
//   bit_in      message bit
//   crc         running CRC, final result after the last bit
module crc16_kermit_serial
    import trig_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic fb;
    assign fb = crc[0] ^ bit_in;

    always_ff @(posedge clk) begin
        if (reset || clr)
            crc <= CRC_INIT;
        else if (en)
            crc <= {1'b0, crc[15:1]} ^ (fb ? CRC_POLY : 16'h0000);
    end

endmodule

// File: rtl/trigger_tx.sv
// DI2C trigger link transmitter (central side). Each accepted request sends
// START, 8 bytes (id, type, serial[31:0], crc16) with an ack cell per byte,
// then STOP and an idle gap. New requests are refused while the wired busy
// line from the sub-systems is high.
//   clk, reset         clock, synchronous active-high reset
//   trig               request handshake (slave side)
//   serial_clear       zero the serial counter
//   trigger_serial     serial for the next frame
//   frame_busy         frame in progress
//   frame_done         pulse in the cycle SDA rises at STOP
//   busy_sync          synchronized ro_busy
//   busy_stuck         sticky, busy held for BUSY_TO cycles
//   ro/ren/de/di_*     SDA, SCL and busy transceiver pins
module trigger_tx
    import trig_pkg::*;
#(
    parameter int          Q_CYC   = 25,
    parameter int          GAP_Q   = 8,
    parameter logic [31:0] BUSY_TO = 32'd100000000
) (
    input  logic        clk,
    input  logic        reset,
    trigger_tx_if.slave trig,
    input  logic        serial_clear,
    output logic [31:0] trigger_serial,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        busy_sync,
    output logic        busy_stuck,
    input  logic        ro_sda,
    output logic        ren_sda,
    output logic        de_sda,
    output logic        di_sda,
    input  logic        ro_scl,
    output logic        ren_scl,
    output logic        de_scl,
    output logic        di_scl,
    input  logic        ro_busy,
    output logic        ren_busy,
    output logic        de_busy,
    output logic        di_busy
);

    state_t      state, state_n;
    logic [9:0]  q_cnt, q_n;          // clk count within a quarter
    logic [1:0]  qtr, qtr_n;          // quarter within START/cell/STOP
    logic [7:0]  cnt, cnt_n;          // CRC bit, cell or gap-quarter index
    logic        sda, sda_n, scl, scl_n;
    logic        done_n, accept, crc_clr, crc_en, q_tick, ready;
    logic [7:0]  id_q, type_q;
    logic [31:0] ser_q;
    logic [15:0] crc;
    logic [47:0] crc_data;
    logic        crc_bit;
    logic [7:0]  fb [FRAME_BYTES];
    logic [CELLS-1:0] cell_vec;       // SDA level per cell, cell 0 at the MSB
    logic        busy_m;
    logic [31:0] busy_cnt;
    logic        unused_pins;

    assign unused_pins = ^{ro_sda, ro_scl};

    assign ren_sda  = 1'b1;
    assign de_sda   = 1'b1;
    assign di_sda   = sda;
    assign ren_scl  = 1'b1;
    assign de_scl   = 1'b1;
    assign di_scl   = scl;
    assign ren_busy = 1'b0;
    assign de_busy  = 1'b0;
    assign di_busy  = 1'b0;

    assign ready           = (state == ST_IDLE) && !busy_sync;
    assign trig.trig_ready = ready;
    assign frame_busy      = (state != ST_IDLE);
    assign q_tick          = (q_cnt == 10'(Q_CYC - 1));

    // CRC walks the 6 header bytes in wire order, each byte LSB first.
    assign crc_data = {id_q, type_q, ser_q};
    assign crc_bit  = crc_data[{3'(3'd5 - cnt[5:3]), cnt[2:0]}];

    crc16_kermit_serial u_crc (
        .clk    (clk),
        .reset  (reset),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (crc_bit),
        .crc    (crc)
    );

    always_comb begin
        fb[BYTE_ID]    = id_q;
        fb[BYTE_TYPE]  = type_q;
        fb[BYTE_SER3]  = ser_q[31:24];
        fb[BYTE_SER2]  = ser_q[23:16];
        fb[BYTE_SER1]  = ser_q[15:8];
        fb[BYTE_SER0]  = ser_q[7:0];
        fb[BYTE_CRC_H] = crc[15:8];
        fb[BYTE_CRC_L] = crc[7:0];
        cell_vec = '0;
        for (int b = 0; b < FRAME_BYTES; b++)
            cell_vec[CELLS-1-BITS_PER_BYTE*b -: BITS_PER_BYTE] = {fb[b], 1'b0};
    end

    // Line levels are registered and updated only on phase boundaries, so
    // SDA moves only at q0 of a cell (SCL low) except at START/STOP.
    always_comb begin
        state_n = state;
        q_n     = q_cnt;
        qtr_n   = qtr;
        cnt_n   = cnt;
        sda_n   = sda;
        scl_n   = scl;
        done_n  = 1'b0;
        accept  = 1'b0;
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        if (state != ST_IDLE && state != ST_CRC)
            q_n = q_tick ? 10'd0 : q_cnt + 10'd1;
        unique case (state)
            ST_IDLE: begin
                sda_n = 1'b1;
                scl_n = 1'b1;
                if (trig.trig_req && ready) begin
                    accept  = 1'b1;
                    crc_clr = 1'b1;
                    cnt_n   = 8'd0;
                    state_n = ST_CRC;
                end
            end
            ST_CRC: begin
                crc_en = 1'b1;
                cnt_n  = cnt + 8'd1;
                if (cnt == 8'(CRC_BITS - 1)) begin
                    state_n = ST_START;
                    sda_n   = 1'b0;
                    q_n     = 10'd0;
                    qtr_n   = 2'd0;
                end
            end
            ST_START: if (q_tick) begin
                qtr_n = qtr + 2'd1;
                if (qtr == 2'd1) begin
                    state_n = ST_BITS;
                    qtr_n   = 2'd0;
                    cnt_n   = 8'd0;
                    scl_n   = 1'b0;
                    sda_n   = cell_vec[CELLS-1];
                end
            end
            ST_BITS: if (q_tick) begin
                qtr_n = qtr + 2'd1;
                if (qtr == 2'd1)
                    scl_n = 1'b1;
                else if (qtr == 2'd3) begin
                    scl_n = 1'b0;
                    if (cnt == 8'(CELLS - 1)) begin
                        state_n = ST_STOP;
                        sda_n   = 1'b0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                        sda_n = cell_vec[7'(CELLS - 2) - cnt[6:0]];
                    end
                end
            end
            ST_STOP: if (q_tick) begin
                qtr_n = qtr + 2'd1;
                if (qtr == 2'd1)
                    scl_n = 1'b1;
                else if (qtr == 2'd3) begin
                    sda_n   = 1'b1;
                    done_n  = 1'b1;
                    state_n = ST_GAP;
                    cnt_n   = 8'd0;
                end
            end
            ST_GAP: if (q_tick) begin
                if (cnt == 8'(GAP_Q - 1))
                    state_n = ST_IDLE;
                else
                    cnt_n = cnt + 8'd1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            q_cnt      <= '0;
            qtr        <= '0;
            cnt        <= '0;
            sda        <= 1'b1;
            scl        <= 1'b1;
            frame_done <= 1'b0;
            id_q       <= '0;
            type_q     <= '0;
            ser_q      <= '0;
        end else begin
            state      <= state_n;
            q_cnt      <= q_n;
            qtr        <= qtr_n;
            cnt        <= cnt_n;
            sda        <= sda_n;
            scl        <= scl_n;
            frame_done <= done_n;
            if (accept) begin
                id_q   <= trig.sub_system_id;
                type_q <= trig.trigger_type;
                ser_q  <= trigger_serial;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || serial_clear)
            trigger_serial <= '0;
        else if (done_n)
            trigger_serial <= trigger_serial + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_m     <= 1'b0;
            busy_sync  <= 1'b0;
            busy_cnt   <= '0;
            busy_stuck <= 1'b0;
        end else begin
            busy_m    <= ro_busy;
            busy_sync <= busy_m;
            if (!busy_sync)
                busy_cnt <= '0;
            else if (busy_cnt != '1)
                busy_cnt <= busy_cnt + 32'd1;
            // this increment makes the count equal BUSY_TO
            if (busy_sync && busy_cnt == BUSY_TO - 32'd1)
                busy_stuck <= 1'b1;
        end
    end

endmodule

// File: tb/tb_trigger_tx.sv
module tb_trigger_tx;
    localparam int Q   = 4;
    localparam int GAP = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        serial_clear = 1'b0;
    logic [31:0] trigger_serial;
    logic        frame_busy, frame_done, busy_sync, busy_stuck;
    logic        ren_sda, de_sda, di_sda, ren_scl, de_scl, di_scl;
    logic        ro_busy = 1'b0;
    logic        ren_busy, de_busy, di_busy;
    logic        c_clr = 1'b0, c_en = 1'b0, c_bit = 1'b0;
    logic [15:0] c_crc;

    trigger_tx_if trig();

    trigger_tx #(.Q_CYC(Q), .GAP_Q(GAP), .BUSY_TO(32'd10)) dut (
        .clk(clk), .reset(reset), .trig(trig), .serial_clear(serial_clear),
        .trigger_serial(trigger_serial), .frame_busy(frame_busy), .frame_done(frame_done),
        .busy_sync(busy_sync), .busy_stuck(busy_stuck),
        .ro_sda(1'b1), .ren_sda(ren_sda), .de_sda(de_sda), .di_sda(di_sda),
        .ro_scl(1'b1), .ren_scl(ren_scl), .de_scl(de_scl), .di_scl(di_scl),
        .ro_busy(ro_busy), .ren_busy(ren_busy), .de_busy(de_busy), .di_busy(di_busy)
    );

    crc16_kermit_serial u_crc_ref (
        .clk(clk), .reset(reset), .clr(c_clr), .en(c_en), .bit_in(c_bit), .crc(c_crc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int start_cnt = 0, stop_cnt = 0, done_cnt = 0, illegal = 0, sda_edges = 0;
    int start_cyc = 0, stop_cyc = 0, done_cyc = 0;
    int drv_cyc = 0, base_stop = 0, base_done = 0;
    logic [31:0] ser_m = 0;
    bit bitq[$];
    bit fbits[$];
    logic prev_sda = 1'b1, prev_scl = 1'b1;

    // Line-level decoder: SDA sampled at each SCL rise; SDA edges with SCL
    // high are START (falling) or STOP (rising) and nothing else.
    initial forever begin
        @(negedge clk);
        if (reset !== 1'b0) bitq.delete();
        else begin
            if (di_scl && !prev_scl) bitq.push_back(di_sda);
            if (di_sda !== prev_sda) begin
                sda_edges++;
                if (di_scl && prev_scl) begin
                    if (!di_sda) begin
                        if (bitq.size() != 0) illegal++;
                        start_cnt++; start_cyc = cyc; bitq.delete();
                    end else begin
                        // 72 cells plus the SCL rise inside STOP
                        if (bitq.size() != 73) illegal++;
                        stop_cnt++; stop_cyc = cyc; fbits = bitq; bitq.delete();
                    end
                end
            end
            if (frame_done) begin done_cnt++; done_cyc = cyc; end
        end
        prev_sda = di_sda;
        prev_scl = di_scl;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] kermit(input logic [7:0] m [6]);
        logic [15:0] c = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            c ^= {8'h00, m[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    task automatic launch(input logic [7:0] id, input logic [7:0] typ);
        int n = 0;
        while (trig.trig_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("ready_wait", 64'(trig.trig_ready), 64'd1);
        base_stop = stop_cnt; base_done = done_cnt;
        trig.sub_system_id = id; trig.trigger_type = typ; trig.trig_req = 1'b1;
        drv_cyc = cyc;
        @(negedge clk);
        trig.trig_req = 1'b0;
    endtask

    task automatic finish_frame(input logic [7:0] id, input logic [7:0] typ, input logic [31:0] ser);
        int n = 0;
        logic [7:0] m [6];
        logic [15:0] c;
        logic [63:0] got = '0;
        logic [7:0] acks = '0;
        while (stop_cnt == base_stop && n < 3000) begin @(negedge clk); n++; end
        check("stop_seen", 64'(stop_cnt - base_stop), 64'd1);
        m = '{id, typ, ser[31:24], ser[23:16], ser[15:8], ser[7:0]};
        c = kermit(m);
        check("frame_bits", 64'(fbits.size()), 64'd73);
        if (fbits.size() >= 72) begin
            for (int b = 0; b < 8; b++) begin
                for (int k = 0; k < 8; k++) got = {got[62:0], fbits[9*b+k]};
                acks[b] = fbits[9*b+8];
            end
        end
        check("frame_data", got, {id, typ, ser, c});
        check("ack_cells", 64'(acks), 64'd0);
        check("start_latency", 64'(start_cyc - drv_cyc), 64'd49);
        check("frame_len", 64'(stop_cyc - start_cyc), 64'(294 * Q));
        check("done_align", 64'(done_cyc), 64'(stop_cyc));
        check("done_count", 64'(done_cnt - base_done), 64'd1);
    endtask

    task automatic do_frame(input logic [7:0] id, input logic [7:0] typ);
        launch(id, typ);
        finish_frame(id, typ, ser_m);
        ser_m++;
        check("serial_after", 64'(trigger_serial), 64'(ser_m));
    endtask

    initial begin
        logic [7:0] msg [9];
        int n, e0;
        trig.trig_req = 1'b0; trig.sub_system_id = '0; trig.trigger_type = '0;

        repeat (3) @(negedge clk);
        check("rst_lines", {62'd0, di_sda, di_scl}, 64'd3);
        check("rst_status", {59'd0, frame_busy, frame_done, busy_sync, busy_stuck, trig.trig_ready}, 64'd1);
        check("rst_serial", 64'(trigger_serial), 64'd0);
        check("xcvr_const", {57'd0, ren_sda, de_sda, ren_scl, de_scl, ren_busy, de_busy, di_busy}, 64'h78);
        reset = 1'b0;
        @(negedge clk);

        do_frame(8'h00, 8'h00);
        for (int i = 0; i < 4; i++) do_frame(8'($urandom), 8'($urandom));
        do_frame(8'hA5, 8'h3C);

        // serial_clear during a frame: frame keeps its latched serial
        launch(8'h77, 8'h88);
        repeat (100) @(negedge clk);
        serial_clear = 1'b1;
        @(negedge clk);
        serial_clear = 1'b0;
        check("serial_clear", 64'(trigger_serial), 64'd0);
        finish_frame(8'h77, 8'h88, ser_m);
        ser_m = 32'd1;
        check("serial_after_clr", 64'(trigger_serial), 64'(ser_m));

        // busy held: request refused, then accepted 2 cycles after release
        n = 0;
        while (frame_busy && n < 200) begin @(negedge clk); n++; end
        ro_busy = 1'b1;
        repeat (3) @(negedge clk);
        e0 = sda_edges;
        trig.sub_system_id = 8'h11; trig.trigger_type = 8'h22; trig.trig_req = 1'b1;
        repeat (5) @(negedge clk);
        check("busy_ready", {62'd0, trig.trig_ready, busy_sync}, 64'd1);
        check("busy_no_sda", 64'(sda_edges - e0), 64'd0);
        check("busy_idle", 64'(frame_busy), 64'd0);
        base_stop = stop_cnt; base_done = done_cnt;
        ro_busy = 1'b0;
        @(negedge clk);
        check("release_1", 64'(trig.trig_ready), 64'd0);
        @(negedge clk);
        check("release_2", 64'(trig.trig_ready), 64'd1);
        drv_cyc = cyc;
        @(negedge clk);
        check("release_acc", 64'(frame_busy), 64'd1);
        trig.trig_req = 1'b0;
        finish_frame(8'h11, 8'h22, ser_m);
        ser_m++;
        check("serial_after_busy", 64'(trigger_serial), 64'(ser_m));
        check("stuck_below", 64'(busy_stuck), 64'd0);

        // reset in the middle of byte 1
        launch(8'h5A, 8'hF0);
        n = 0;
        while (bitq.size() < 13 && n < 2000) begin @(negedge clk); n++; end
        check("midframe_reach", 64'(bitq.size() >= 13), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_lines", {61'd0, di_sda, di_scl, frame_busy}, 64'd6);
        check("abort_serial", 64'(trigger_serial), 64'd0);
        check("abort_no_done", 64'(done_cnt - base_done), 64'd0);
        reset = 1'b0;
        ser_m = 32'd0;
        @(negedge clk);
        do_frame(8'h12, 8'h34);

        // busy held past BUSY_TO
        ro_busy = 1'b1;
        repeat (12) @(negedge clk);
        ro_busy = 1'b0;
        repeat (4) @(negedge clk);
        check("stuck_set", 64'(busy_stuck), 64'd1);
        repeat (10) @(negedge clk);
        check("stuck_sticky", 64'(busy_stuck), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("stuck_reset", 64'(busy_stuck), 64'd0);
        reset = 1'b0;

        // standalone CRC check value
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c_clr = 1'b1;
        @(negedge clk);
        c_clr = 1'b0;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8; j++) begin
                c_en = 1'b1; c_bit = msg[i][j];
                @(negedge clk);
            end
        c_en = 1'b0;
        check("crc_check_val", 64'(c_crc), 64'h2189);

        check("line_protocol", 64'(illegal), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
